// File: rtl/triangle_wireframe_drawer_if.sv
// Pixel output bus of the triangle wireframe drawer.
// master: pix_valid, pix_x, pix_y out, pix_ready in; slave mirrors.
interface triangle_wireframe_drawer_if #(
    parameter int CW = 10
);
    logic          pix_valid;
    logic          pix_ready;
    logic [CW-1:0] pix_x;
    logic [CW-1:0] pix_y;

    modport master (
        output pix_valid,
        output pix_x,
        output pix_y,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_x,
        input  pix_y,
        output pix_ready
    );
endinterface

// File: rtl/triangle_wireframe_drawer.sv
// Draws the three edges of a screen-space triangle with Bresenham lines.
// Ports: Clk, Reset_n, start, proj_triangle in; busy, done out; pix bus (master).
module triangle_wireframe_drawer #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int CW    = 10
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       start,
    input  logic [2:0][1:0][CW-1:0]    proj_triangle,
    output logic                       busy,
    output logic                       done,
    triangle_wireframe_drawer_if.master pix
);

    localparam int EW = CW + 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] DRAW  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [CW:0] H_LIM = (CW+1)'(H_RES);
    localparam logic [CW:0] V_LIM = (CW+1)'(V_RES);

    logic [1:0]                state;
    logic [2:0][1:0][CW-1:0]   vtx;
    logic [1:0]                edge_idx;
    logic [CW-1:0]             x;
    logic [CW-1:0]             y;
    logic [CW-1:0]             xe;
    logic [CW-1:0]             ye;
    logic signed [EW-1:0]      dx;
    logic signed [EW-1:0]      dy;
    logic signed [EW-1:0]      err;
    logic                      sx_neg;
    logic                      sy_neg;

    // Endpoints of the edge selected by edge_idx
    logic [CW-1:0] xa_s, ya_s, xb_s, yb_s;

    always_comb begin
        xa_s = vtx[2][0];
        ya_s = vtx[2][1];
        xb_s = vtx[0][0];
        yb_s = vtx[0][1];
        case (edge_idx)
            2'd0: begin
                xa_s = vtx[0][0];
                ya_s = vtx[0][1];
                xb_s = vtx[1][0];
                yb_s = vtx[1][1];
            end
            2'd1: begin
                xa_s = vtx[1][0];
                ya_s = vtx[1][1];
                xb_s = vtx[2][0];
                yb_s = vtx[2][1];
            end
            default: ;
        endcase
    end

    logic signed [EW-1:0] ddx, ddy, adx, ady;

    always_comb begin
        ddx = $signed({2'b00, xb_s}) - $signed({2'b00, xa_s});
        ddy = $signed({2'b00, yb_s}) - $signed({2'b00, ya_s});
        adx = (ddx < 0) ? -ddx : ddx;
        ady = (ddy < 0) ? -ddy : ddy;
    end

    // Doubled error is one bit wider so it never wraps
    logic signed [EW:0] e2, dx_w, dy_w;
    logic signed [EW-1:0] err_n;
    logic step_x, step_y;

    assign e2   = {err, 1'b0};
    assign dx_w = {dx[EW-1], dx};
    assign dy_w = {dy[EW-1], dy};

    always_comb begin
        step_x = (e2 >= dy_w);
        step_y = (e2 <= dx_w);
        err_n  = err;
        if (step_x) err_n = err_n + dy;
        if (step_y) err_n = err_n + dx;
    end

    logic in_range, at_end, advance;

    assign in_range = ({1'b0, x} < H_LIM) && ({1'b0, y} < V_LIM);
    assign at_end   = (x == xe) && (y == ye);

    assign pix.pix_valid = (state == DRAW) && in_range;
    assign pix.pix_x     = x;
    assign pix.pix_y     = y;

    // Off-screen points complete without waiting for downstream
    assign advance = pix.pix_valid ? pix.pix_ready : 1'b1;

    assign busy = (state == SETUP) || (state == DRAW);
    assign done = (state == DONE);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            vtx      <= '0;
            edge_idx <= '0;
            x        <= '0;
            y        <= '0;
            xe       <= '0;
            ye       <= '0;
            dx       <= '0;
            dy       <= '0;
            err      <= '0;
            sx_neg   <= 1'b0;
            sy_neg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        vtx      <= proj_triangle;
                        edge_idx <= 2'd0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    x      <= xa_s;
                    y      <= ya_s;
                    xe     <= xb_s;
                    ye     <= yb_s;
                    dx     <= adx;
                    dy     <= -ady;
                    err    <= adx - ady;
                    sx_neg <= (xb_s < xa_s);
                    sy_neg <= (yb_s < ya_s);
                    state  <= DRAW;
                end
                DRAW: begin
                    if (advance) begin
                        if (at_end) begin
                            if (edge_idx == 2'd2) begin
                                state <= DONE;
                            end else begin
                                edge_idx <= edge_idx + 2'd1;
                                state    <= SETUP;
                            end
                        end else begin
                            err <= err_n;
                            if (step_x)
                                x <= sx_neg ? x - 1'b1 : x + 1'b1;
                            if (step_y)
                                y <= sy_neg ? y - 1'b1 : y + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_triangle_wireframe_drawer.sv
// Scoreboard bench for triangle_wireframe_drawer.
// Directed triangles; a negedge monitor pops expected pixels on each handshake.
module tb_triangle_wireframe_drawer;

    localparam int CW = 10;

    logic                    Clk = 1'b0;
    logic                    Reset_n = 1'b0;
    logic                    start = 1'b0;
    logic [2:0][1:0][CW-1:0] tri_in = '0;
    logic                    busy;
    logic                    done;

    triangle_wireframe_drawer_if #(.CW(CW)) pix ();

    triangle_wireframe_drawer #(
        .H_RES(640),
        .V_RES(480),
        .CW(CW)
    ) u_dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .start(start),
        .proj_triangle(tri_in),
        .busy(busy),
        .done(done),
        .pix(pix)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int x;
        int y;
        int cyc;
    } exp_t;

    exp_t sb[$];

    int tests_run = 0;
    int fails = 0;
    int done_cnt = 0;
    int rel = 0;
    int exp_done_cyc = -1;
    bit ready_toggle = 1'b0;
    logic stall_prev = 1'b0;
    logic [CW-1:0] px_prev = '0;
    logic [CW-1:0] py_prev = '0;

    task automatic check(input string name, input int act, input int req);
        tests_run++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic push(input int x, input int y, input int c = -1);
        exp_t e;
        e.x = x;
        e.y = y;
        e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic set_tri(input int x0, input int y0, input int x1,
                           input int y1, input int x2, input int y2);
        tri_in[0][0] = CW'(x0);
        tri_in[0][1] = CW'(y0);
        tri_in[1][0] = CW'(x1);
        tri_in[1][1] = CW'(y1);
        tri_in[2][0] = CW'(x2);
        tri_in[2][1] = CW'(y2);
    endtask

    task automatic launch(input int x0, input int y0, input int x1,
                          input int y1, input int x2, input int y2);
        @(posedge Clk);
        #1;
        set_tri(x0, y0, x1, y1, x2, y2);
        start = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < 1000) begin
            @(posedge Clk);
            n++;
        end
        check(name, done_cnt, target);
        repeat (3) @(posedge Clk);
        check({name, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic push_tri_a(input bit timed);
        push(0, 0, timed ? 2 : -1);
        push(1, 0, timed ? 3 : -1);
        push(2, 0, timed ? 4 : -1);
        push(3, 0, timed ? 5 : -1);
        push(3, 0, timed ? 7 : -1);
        push(2, 1, timed ? 8 : -1);
        push(1, 2, timed ? 9 : -1);
        push(0, 3, timed ? 10 : -1);
        push(0, 3, timed ? 12 : -1);
        push(0, 2, timed ? 13 : -1);
        push(0, 1, timed ? 14 : -1);
        push(0, 0, timed ? 15 : -1);
    endtask

    // Downstream ready: constant 1 or toggling every cycle
    initial begin
        pix.pix_ready = 1'b1;
        forever begin
            @(posedge Clk);
            #1;
            if (ready_toggle)
                pix.pix_ready = ~pix.pix_ready;
            else
                pix.pix_ready = 1'b1;
        end
    end

    // Monitor: cycle tracking, stall stability, scoreboard pops, done pulses
    always @(negedge Clk) begin
        if (!Reset_n) begin
            stall_prev = 1'b0;
        end else begin
            if (start && !busy && !done)
                rel = 0;
            else
                rel++;
            if (stall_prev) begin
                check("stall_valid", int'(pix.pix_valid), 1);
                check("stall_x", int'(pix.pix_x), int'(px_prev));
                check("stall_y", int'(pix.pix_y), int'(py_prev));
            end
            if (pix.pix_valid && pix.pix_ready) begin
                if (sb.size() == 0) begin
                    tests_run++;
                    fails++;
                    $display("FAIL unexpected_pixel: got (%0d,%0d), want none",
                             pix.pix_x, pix.pix_y);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("pix_x", int'(pix.pix_x), e.x);
                    check("pix_y", int'(pix.pix_y), e.y);
                    if (e.cyc >= 0)
                        check("pix_cycle", rel, e.cyc);
                end
            end
            stall_prev = pix.pix_valid && !pix.pix_ready;
            px_prev = pix.pix_x;
            py_prev = pix.pix_y;
            if (done) begin
                done_cnt++;
                check("done_after_last", sb.size(), 0);
                check("done_not_busy", int'(busy), 0);
                if (exp_done_cyc >= 0)
                    check("done_cycle", rel, exp_done_cyc);
            end
        end
    end

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_valid", int'(pix.pix_valid), 0);
        check("rst_x", int'(pix.pix_x), 0);
        check("rst_y", int'(pix.pix_y), 0);
        Reset_n = 1'b1;
        repeat (2) @(posedge Clk);

        // Basic triangle, full-rate ready, exact cycle timing
        push_tri_a(1'b1);
        exp_done_cyc = 16;
        launch(0, 0, 3, 0, 0, 3);
        wait_done(1, "tri_a_done");
        exp_done_cyc = -1;

        // Same triangle with ready toggling
        ready_toggle = 1'b1;
        push_tri_a(1'b0);
        launch(0, 0, 3, 0, 0, 3);
        wait_done(2, "tri_a_stall_done");
        ready_toggle = 1'b0;
        repeat (2) @(posedge Clk);

        // Right-edge clipping
        push(638, 10);
        push(639, 10);
        push(639, 10);
        push(638, 10);
        push(638, 10);
        launch(638, 10, 641, 10, 638, 10);
        wait_done(3, "clip_done");

        // Fully degenerate triangle
        push(5, 5);
        push(5, 5);
        push(5, 5);
        launch(5, 5, 5, 5, 5, 5);
        wait_done(4, "degen_done");

        // Steep edge; start and input changes while busy are ignored
        push(0, 0);
        push(0, 1);
        push(1, 2);
        push(1, 3);
        push(1, 4);
        push(1, 4);
        push(1, 3);
        push(0, 2);
        push(0, 1);
        push(0, 0);
        push(0, 0);
        launch(0, 0, 1, 4, 0, 0);
        repeat (3) @(posedge Clk);
        #1;
        set_tri(100, 100, 200, 50, 7, 9);
        start = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
        wait_done(5, "steep_done");
        repeat (30) @(posedge Clk);
        check("steep_single_done", done_cnt, 5);

        // Reset in the middle of an edge
        push_tri_a(1'b0);
        launch(0, 0, 3, 0, 0, 3);
        repeat (7) @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_valid", int'(pix.pix_valid), 0);
        check("mid_rst_x", int'(pix.pix_x), 0);
        check("mid_rst_y", int'(pix.pix_y), 0);
        sb.delete();
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        repeat (10) @(posedge Clk);
        #1;
        check("post_rst_idle", int'(busy), 0);
        check("post_rst_no_done", done_cnt, 5);

        // Redraw after reset starts again from edge 0
        push_tri_a(1'b0);
        launch(0, 0, 3, 0, 0, 3);
        wait_done(6, "redraw_done");

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
